// File: rtl/demux_1_to_8_pkg.sv
// Shared widths and types for the registered 1-to-8 demultiplexer.
// NUM_OUT is fixed at 8, and SEL_W must stay equal to log2(NUM_OUT).
package demux_1_to_8_pkg;

  localparam int DATA_W  = 16;
  localparam int NUM_OUT = 8;
  localparam int SEL_W   = 3;

  typedef logic [DATA_W-1:0]  data_t;
  typedef logic [SEL_W-1:0]   sel_t;
  typedef logic [NUM_OUT-1:0] onehot_t;

endpackage

// File: rtl/demux_sel_decoder.sv
// Combinational selector-to-one-hot decoder with an enable input.
// A selector that matches no code drives an all-zero output.
module demux_sel_decoder
  import demux_1_to_8_pkg::*;
(
  input  logic    en,
  input  sel_t    sel,
  output onehot_t onehot
);

  // An unknown selector compares false against every code, so no bit is set.
  always_comb begin
    onehot = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      if (en && (sel == sel_t'(k))) begin
        onehot[k] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demux_1_to_8.sv
// Registered 1-to-8 demultiplexer with one cycle of latency.
// When DEMUX1_8_HOLD_EN is defined, outputs that are not loaded keep their value instead of clearing.
module demux_1_to_8
  import demux_1_to_8_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [DATA_W-1:0]   in1,
  input  logic                in_valid,
  input  logic [SEL_W-1:0]    selector,
  output logic [DATA_W-1:0]   output1,
  output logic [DATA_W-1:0]   output2,
  output logic [DATA_W-1:0]   output3,
  output logic [DATA_W-1:0]   output4,
  output logic [DATA_W-1:0]   output5,
  output logic [DATA_W-1:0]   output6,
  output logic [DATA_W-1:0]   output7,
  output logic [DATA_W-1:0]   output8,
  output logic [NUM_OUT-1:0]  out_valid
);

  onehot_t load;
  data_t   port_d [NUM_OUT];
  data_t   port_q [NUM_OUT];
  onehot_t valid_d;
  onehot_t valid_q;

  demux_sel_decoder u_decoder (
    .en     (in_valid),
    .sel    (selector),
    .onehot (load)
  );

  always_comb begin
    valid_d = load;
    for (int k = 0; k < NUM_OUT; k++) begin
`ifdef DEMUX1_8_HOLD_EN
      port_d[k] = load[k] ? in1 : port_q[k];
`else
      port_d[k] = load[k] ? in1 : '0;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < NUM_OUT; k++) begin
        port_q[k] <= '0;
      end
    end else begin
      valid_q <= valid_d;
      for (int k = 0; k < NUM_OUT; k++) begin
        port_q[k] <= port_d[k];
      end
    end
  end

  assign output1   = port_q[0];
  assign output2   = port_q[1];
  assign output3   = port_q[2];
  assign output4   = port_q[3];
  assign output5   = port_q[4];
  assign output6   = port_q[5];
  assign output7   = port_q[6];
  assign output8   = port_q[7];
  assign out_valid = valid_q;

endmodule

// File: tb/tb_demux_1_to_8.sv
// Self-checking bench for demux_1_to_8: directed cases followed by random traffic.
// The expected outputs come from a port-array model that applies the routing rules directly.
module tb_demux_1_to_8;

  logic        clk;
  logic        rst;
  logic [15:0] in1;
  logic        in_valid;
  logic [2:0]  selector;
  logic [15:0] output1, output2, output3, output4;
  logic [15:0] output5, output6, output7, output8;
  logic [7:0]  out_valid;

  logic [15:0] obs [8];
  logic [15:0] exp_port [8];
  logic [7:0]  exp_valid;
  int          num_checks;
  int          num_passed;

  demux_1_to_8 dut (
    .clk       (clk),
    .rst       (rst),
    .in1       (in1),
    .in_valid  (in_valid),
    .selector  (selector),
    .output1   (output1),
    .output2   (output2),
    .output3   (output3),
    .output4   (output4),
    .output5   (output5),
    .output6   (output6),
    .output7   (output7),
    .output8   (output8),
    .out_valid (out_valid)
  );

  assign obs[0] = output1;
  assign obs[1] = output2;
  assign obs[2] = output3;
  assign obs[3] = output4;
  assign obs[4] = output5;
  assign obs[5] = output6;
  assign obs[6] = output7;
  assign obs[7] = output8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    num_checks++;
    if (observed === expected) begin
      num_passed++;
    end else begin
      $display("[TB] FAIL %s: got %h, want %h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag);
    for (int k = 0; k < 8; k++) begin
      checkOutput($sformatf("%s output%0d", tag, k + 1), obs[k], exp_port[k]);
    end
    checkOutput($sformatf("%s out_valid", tag), {8'h00, out_valid}, {8'h00, exp_valid});
  endtask

  task automatic resetModel();
    for (int k = 0; k < 8; k++) exp_port[k] = 16'h0000;
    exp_valid = 8'h00;
  endtask

  // Drive one word, let it cross a clock edge, advance the model, then check every port.
  task automatic applyStimulus(input logic [15:0] word, input logic [2:0] sel, input logic valid, input string tag);
    in1      = word;
    selector = sel;
    in_valid = valid;
    @(posedge clk);
    #1;
    for (int k = 0; k < 8; k++) begin
      if (valid && (int'(sel) == k)) begin
        exp_port[k] = word;
      end else begin
`ifndef DEMUX1_8_HOLD_EN
        exp_port[k] = 16'h0000;
`endif
      end
    end
    exp_valid = valid ? (8'h01 << sel) : 8'h00;
    checkAll(tag);
  endtask

  initial begin
    num_checks = 0;
    num_passed = 0;
    resetModel();

    // Reset must clear everything before any clock edge arrives.
    rst      = 1'b1;
    in1      = 16'h3524;
    selector = 3'd5;
    in_valid = 1'b1;
    #3;
    checkAll("reset_no_edge");
    @(posedge clk);
    #1;
    checkAll("reset_with_edge");
    @(negedge clk);
    rst = 1'b0;

    for (int k = 0; k < 8; k++) begin
      applyStimulus(16'h3524, 3'(k), 1'b1, $sformatf("sweep%0d", k));
    end

    applyStimulus(16'hAAAA, 3'd2, 1'b1, "b2b_first");
    applyStimulus(16'h5555, 3'd2, 1'b1, "b2b_second");

    applyStimulus(16'hFFFF, 3'd7, 1'b0, "idle");

    applyStimulus(16'h1111, 3'd0, 1'b1, "hold_a");
    applyStimulus(16'h2222, 3'd1, 1'b1, "hold_b");

    // Reset between clock edges must clear the ports without waiting for an edge.
    applyStimulus(16'hC0DE, 3'd4, 1'b1, "stream4_a");
    applyStimulus(16'hBEEF, 3'd4, 1'b1, "stream4_b");
    #2;
    rst = 1'b1;
    #1;
    resetModel();
    checkAll("midreset");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(16'h0F0F, 3'd1, 1'b1, "after_reset");

    for (int i = 0; i < 40; i++) begin
      applyStimulus(16'($urandom), 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 3) != 0), $sformatf("rand%0d", i));
    end

    $display("%0d/%0d checks passed", num_passed, num_checks);
    $finish;
  end

endmodule
